// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller with occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush, sticky error flags
// and a choice of show-ahead or registered read data.
module sync_fifo_ctl #(
  parameter int width     = 8,
  parameter int widthad   = 9,
  parameter int afull_th  = 480,
  parameter int aempty_th = 32,
  parameter int showahead = 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [width-1:0]   D,
  input  logic               WR,
  input  logic               RD,
  input  logic               FLUSH,
  input  logic               CLR_ERR,
  output logic [width-1:0]   Q,
  output logic               QV,
  output logic [widthad:0]   CNT,
  output logic               FULL,
  output logic               EMPTY,
  output logic               AFULL,
  output logic               AEMPTY,
  output logic               OVF,
  output logic               UDF
);

  localparam int DEPTH = 2 ** widthad;
  localparam logic [widthad:0] DEPTH_LV  = (widthad + 1)'(DEPTH);
  localparam logic [widthad:0] AFULL_LV  = (widthad + 1)'(afull_th);
  localparam logic [widthad:0] AEMPTY_LV = (widthad + 1)'(aempty_th);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [widthad:0]   wcnt_q, wcnt_d;
  logic [widthad:0]   rcnt_q, rcnt_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic [widthad:0]   cnt;
  logic               wr_ok;
  logic               rd_ok;
  logic [widthad-1:0] wp;
  logic [widthad-1:0] rp;
  logic [width-1:0]   mem [DEPTH];

  assign cnt    = wcnt_q - rcnt_q;
  assign wp     = wcnt_q[widthad-1:0];
  assign rp     = rcnt_q[widthad-1:0];
  assign CNT    = cnt;
  assign FULL   = (cnt == DEPTH_LV);
  assign EMPTY  = (cnt == '0);
  assign AFULL  = (cnt >= AFULL_LV);
  assign AEMPTY = (cnt <= AEMPTY_LV);
  assign OVF    = ovf_q;
  assign UDF    = udf_q;

  // Accept/reject each request against the flags seen before the edge;
  // flush overrides both and leaves the error flags alone.
  always_comb begin
    wr_ok  = WR & ~FULL & ~FLUSH;
    rd_ok  = RD & ~EMPTY & ~FLUSH;
    wcnt_d = wcnt_q + (widthad + 1)'(wr_ok);
    rcnt_d = FLUSH ? wcnt_q : rcnt_q + (widthad + 1)'(rd_ok);
    // A new error in the same cycle as CLR_ERR wins over the clear.
    ovf_d  = (ovf_q & ~CLR_ERR) | (WR & FULL & ~FLUSH);
    udf_d  = (udf_q & ~CLR_ERR) | (RD & EMPTY & ~FLUSH);
  end

  // Pointer and sticky error state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wp] <= D;
    end
  end

  if (showahead != 0) begin : g_showahead
    // Head word is presented directly from the array.
    assign Q  = mem[rp];
    assign QV = 1'b0;
  end else begin : g_registered
    logic [width-1:0] q_q, q_d;
    logic             qv_q, qv_d;

    // Capture the head word on an accepted read; hold it otherwise.
    always_comb begin
      q_d  = rd_ok ? mem[rp] : q_q;
      qv_d = rd_ok;
    end

    // Registered read data and its one-cycle valid strobe.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        q_q  <= '0;
        qv_q <= 1'b0;
      end else begin
        q_q  <= q_d;
        qv_q <= qv_d;
      end
    end

    assign Q  = q_q;
    assign QV = qv_q;
  end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Scoreboard bench for sync_fifo_ctl: a show-ahead and a registered
// instance share one randomized/directed stimulus stream and are checked
// against a queue-based model of FIFO behaviour.
module tb_sync_fifo_ctl;

  localparam int W  = 8;
  localparam int AD = 4;
  localparam int DP = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [W-1:0]  D;
  logic          WR, RD, FLUSH, CLR_ERR;

  logic [W-1:0]  q_a, q_b;
  logic          qv_a, qv_b;
  logic [AD:0]   cnt_a, cnt_b;
  logic          full_a, empty_a, afull_a, aempty_a, ovf_a, udf_a;
  logic          full_b, empty_b, afull_b, aempty_b, ovf_b, udf_b;

  sync_fifo_ctl #(.width(W), .widthad(AD), .afull_th(AF), .aempty_th(AE), .showahead(1)) dut_a (
    .CLK(CLK), .nRST(nRST), .D(D), .WR(WR), .RD(RD), .FLUSH(FLUSH), .CLR_ERR(CLR_ERR),
    .Q(q_a), .QV(qv_a), .CNT(cnt_a), .FULL(full_a), .EMPTY(empty_a), .AFULL(afull_a),
    .AEMPTY(aempty_a), .OVF(ovf_a), .UDF(udf_a));

  sync_fifo_ctl #(.width(W), .widthad(AD), .afull_th(AF), .aempty_th(AE), .showahead(0)) dut_b (
    .CLK(CLK), .nRST(nRST), .D(D), .WR(WR), .RD(RD), .FLUSH(FLUSH), .CLR_ERR(CLR_ERR),
    .Q(q_b), .QV(qv_b), .CNT(cnt_b), .FULL(full_b), .EMPTY(empty_b), .AFULL(afull_b),
    .AEMPTY(aempty_b), .OVF(ovf_b), .UDF(udf_b));

  always #5 CLK = ~CLK;

  int npass = 0;
  int nchk  = 0;

  // Reference model: contents as a queue plus the two sticky flags.
  logic [W-1:0] mq[$];
  bit           m_ovf, m_udf;
  // Expected read words for each instance.
  logic [W-1:0] exp_sa[$];
  logic [W-1:0] exp_rg[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_state();
    int sz;
    sz = mq.size();
    chk("cnt_a",    cnt_a,    sz);
    chk("full_a",   full_a,   sz == DP);
    chk("empty_a",  empty_a,  sz == 0);
    chk("afull_a",  afull_a,  sz >= AF);
    chk("aempty_a", aempty_a, sz <= AE);
    chk("ovf_a",    ovf_a,    m_ovf);
    chk("udf_a",    udf_a,    m_udf);
    chk("qv_a_tied", qv_a,    0);
    chk("cnt_b",    cnt_b,    sz);
    chk("full_b",   full_b,   sz == DP);
    chk("empty_b",  empty_b,  sz == 0);
    chk("ovf_b",    ovf_b,    m_ovf);
    chk("udf_b",    udf_b,    m_udf);
  endtask

  // One clock of stimulus: check the state left by the previous edge,
  // then drive new inputs and advance the model to the upcoming edge.
  task automatic step(input bit wr, input bit rd, input bit fl, input bit ce, input logic [W-1:0] d);
    bit full, empty;
    @(posedge CLK);
    #2;
    check_state();
    WR = wr; RD = rd; FLUSH = fl; CLR_ERR = ce; D = d;
    full  = (mq.size() == DP);
    empty = (mq.size() == 0);
    m_ovf = (m_ovf & ~ce) | (wr & full & ~fl);
    m_udf = (m_udf & ~ce) | (rd & empty & ~fl);
    if (fl) begin
      mq.delete();
    end else begin
      if (rd && !empty) begin
        exp_sa.push_back(mq[0]);
        exp_rg.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (wr && !full) mq.push_back(d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
  endtask

  // Asynchronous reset away from the clock edge, then check reset values.
  task automatic do_reset();
    @(posedge CLK);
    #2;
    WR = 0; RD = 0; FLUSH = 0; CLR_ERR = 0; D = '0;
    nRST = 1'b0;
    #1;
    mq.delete(); exp_sa.delete(); exp_rg.delete();
    m_ovf = 0; m_udf = 0;
    check_state();
    chk("rst_aempty_b", aempty_b, 1);
    chk("rst_afull_b",  afull_b,  0);
    chk("rst_q_b",      q_b,      0);
    chk("rst_qv_b",     qv_b,     0);
    #1;
    nRST = 1'b1;
  endtask

  // Monitor: compares read data whenever an instance presents a word.
  initial begin
    forever begin
      @(negedge CLK);
      if (nRST && RD && !FLUSH && !empty_a) begin
        if (exp_sa.size() == 0) chk("sa_unexpected_read", 1, 0);
        else chk("sa_q", q_a, exp_sa.pop_front());
      end
      if (qv_b) begin
        if (exp_rg.size() == 0) chk("rg_unexpected_qv", 1, 0);
        else chk("rg_q", q_b, exp_rg.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    WR = 0; RD = 0; FLUSH = 0; CLR_ERR = 0; D = '0;
    nRST = 1'b0;
    m_ovf = 0; m_udf = 0;
    #12;
    check_state();
    chk("rst_q_b", q_b, 0);
    chk("rst_qv_b", qv_b, 0);
    nRST = 1'b1;

    // Five writes, then five reads in order.
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, W'(i));
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'h00);
    idle(2);

    // Fill to full, overflow, read+write while full, clear error.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, W'(8'h10 + i));
    step(1, 0, 0, 0, 8'hEE);
    step(1, 1, 0, 0, 8'hEF);
    step(0, 0, 0, 1, 8'h00);
    idle(1);

    // Drain, underflow, read+write on empty.
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 8'h77);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    idle(1);

    // Continuous streaming across pointer wrap.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, W'(8'h80 + i));
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0, W'(8'h90 + i));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00);
    idle(1);

    // Flush with nine words stored while reading and writing.
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, W'(8'h40 + i));
    step(1, 1, 1, 0, 8'hCC);
    idle(2);
    step(0, 0, 0, 1, 8'h00);

    // Two known words through both read modes.
    step(1, 0, 0, 0, 8'hA5);
    step(1, 0, 0, 0, 8'h5A);
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    idle(2);

    // Randomized traffic in phases biased toward filling and draining,
    // with an asynchronous reset in the middle of the stream.
    for (int i = 0; i < 600; i++) begin
      int ph, pw, pr;
      ph = (i / 100) % 3;
      pw = (ph == 0) ? 80 : (ph == 1) ? 30 : 50;
      pr = (ph == 0) ? 30 : (ph == 1) ? 80 : 50;
      if (i == 300) begin
        step(1, 1, 0, 0, W'($urandom));
        do_reset();
      end
      step($urandom_range(99) < pw, $urandom_range(99) < pr,
           $urandom_range(99) < 2, $urandom_range(99) < 5, W'($urandom));
    end
    idle(3);

    chk("sa_drained", exp_sa.size(), 0);
    chk("rg_drained", exp_rg.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctl.md
Name: sync_fifo_ctl

Overview:
- Parametrised single-clock FIFO; successor to the team's basic 2^n-deep FIFO.
- Adds occupancy count output, programmable almost-full/almost-empty flags, synchronous flush, sticky overflow/underflow error flags, and a selectable read mode (show-ahead or registered).
- Sits between DMA descriptor/data producers and consumers in the PCIe DMA datapath on a single clock.

Parameters:
- width, 8, data bus width.
- widthad, 9, address width; depth = 2**widthad words.
- afull_th, 480, AFULL asserted when CNT >= afull_th (legal range 1..2**widthad).
- aempty_th, 32, AEMPTY asserted when CNT <= aempty_th (legal range 0..2**widthad-1).
- showahead, 1, 1 = head word visible combinationally on Q; 0 = registered read with QV strobe.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- nRST  in  1  asynchronous active-low reset.
- D  in  width  write data.
- WR  in  1  write request.
- RD  in  1  read request.
- FLUSH  in  1  synchronous clear of contents.
- CLR_ERR  in  1  clears OVF/UDF.
- Q  out  width  read data.
- QV  out  1  read-data valid strobe; showahead=0 only, tied 0 when showahead=1.
- CNT  out  widthad+1  words stored.
- FULL  out  1  CNT == 2**widthad.
- EMPTY  out  1  CNT == 0.
- AFULL  out  1  almost full.
- AEMPTY  out  1  almost empty.
- OVF  out  1  sticky: write attempted while full.
- UDF  out  1  sticky: read attempted while empty.

Behaviour:
- Pointers:
  - WCNT/RCNT are widthad+1-bit counters; low widthad bits address the RAM.
  - CNT = WCNT - RCNT, modulo 2^(widthad+1).
  - Wrap-around is natural binary rollover; no reset needed at wrap.
- Reset (nRST low, asynchronous):
  - WCNT=RCNT=0, so CNT=0, EMPTY=1, FULL=0, AFULL=0, AEMPTY=1.
  - OVF=UDF=0, QV=0, Q register=0 (showahead=0). RAM is not reset.
- Write:
  - Accepted when WR & ~FULL & ~FLUSH: RAM[WP] <= D, WCNT+1.
  - WR & FULL: data dropped, pointers unchanged, OVF<=1.
- Read:
  - Accepted when RD & ~EMPTY & ~FLUSH: RCNT+1.
  - RD & EMPTY: no pointer change, UDF<=1.
- Simultaneous RD and WR:
  - Each is judged independently against flags sampled before the edge.
  - Full: only the read is accepted (CNT-1), OVF set.
  - Empty: only the write is accepted (CNT+1), UDF set.
  - Otherwise CNT is unchanged.
- FLUSH:
  - Highest priority over WR/RD; sets RCNT<=WCNT, so CNT=0 next cycle.
  - Does not set or clear OVF/UDF; QV=0 that cycle.
- CLR_ERR:
  - Clears OVF/UDF next edge.
  - If a new error occurs in the same cycle, set wins.
- Flags:
  - FULL, EMPTY, AFULL and AEMPTY are combinational from CNT, so they update the cycle after the causing edge.
- showahead=1: Q = RAM[RP] combinationally. Q is undefined/stale when EMPTY. Read latency 0.
- showahead=0:
  - On an accepted read, Q <= RAM[RP] and QV <= 1 at the same edge; Q is valid in the following cycle.
  - QV is otherwise 0. Q holds its last value between reads.
  - Back-to-back reads deliver one word per cycle.
- Latency: a word written at edge N is readable (showahead Q / RD accepted) from edge N+1.

Test Plan:
- Reset, then write 0x01..0x05 (width=8, widthad=4, afull_th=12, aempty_th=2) -> CNT=5, EMPTY=0, AEMPTY=0; showahead=1 Q=0x01 immediately; 5 reads return 0x01..0x05 in order, EMPTY=1 after the last.
- Write 16 words -> FULL=1 and AFULL=1 from word 12; 17th write dropped, OVF=1, CNT stays 16. Simultaneous RD+WR while full -> CNT=15, OVF remains set; CLR_ERR -> OVF=0.
- RD on empty FIFO -> UDF=1, CNT=0. RD+WR on empty -> CNT=1, UDF set, written word readable next cycle.
- Stream 40 words through depth 16 with continuous RD+WR -> pointers wrap; output sequence matches input exactly, CNT constant.
- FLUSH with 9 words stored while WR=RD=1 -> CNT=0, EMPTY=1 next cycle; the write is not stored; OVF/UDF unchanged.
- showahead=0: write 0xA5, 0x5A; RD two cycles -> QV=1 on the two cycles after the read edges with Q=0xA5 then 0x5A. Assert nRST mid-stream -> all outputs return to reset values asynchronously.
